myip_v1_0: RTL and testbench
============================

MYIP_V1_0 -- requirements
Module: myip_v1_0

Interface
REQ-001 Parameter NUMBER_OF_INPUT_WORDS, default 2: words accepted per frame; legal range 1..256.
REQ-002 Parameter NUMBER_OF_OUTPUT_WORDS, default 1: words emitted per frame; legal range 1..256.
REQ-003 Port ACLK, input, 1: sole clock; all state updates on its rising edge.
REQ-004 Port ARESETN, input, 1: reset, asynchronous, active-low.
REQ-005 Port S_AXIS_TREADY, output, 1: slave stream ready.
REQ-006 Port S_AXIS_TDATA, input, 32: slave stream data.
REQ-007 Port S_AXIS_TLAST, input, 1: slave stream last; ignored, because frame length is set by NUMBER_OF_INPUT_WORDS.
REQ-008 Port S_AXIS_TVALID, input, 1: slave stream valid.
REQ-009 Port M_AXIS_TVALID, output, 1: master stream valid.
REQ-010 Port M_AXIS_TDATA, output, 32: master stream data.
REQ-011 Port M_AXIS_TLAST, output, 1: master stream last.
REQ-012 Port M_AXIS_TREADY, input, 1: master stream ready.
REQ-013 Port order SHALL be exactly as listed in REQ-003..REQ-012 for positional instantiation.

Function
REQ-014 The FSM SHALL have three states: IDLE, READ_INPUTS and WRITE_OUTPUTS.
REQ-015 IDLE:
- S_AXIS_TREADY=0 and M_AXIS_TVALID=0.
- Moves to READ_INPUTS on the first edge with S_AXIS_TVALID=1.
- Sum register cleared to 0 and input counter cleared to 0.
REQ-016 READ_INPUTS:
- S_AXIS_TREADY=1 and M_AXIS_TVALID=0.
- On each edge with S_AXIS_TVALID=1: sum <= sum + S_AXIS_TDATA, and the input counter increments.
- Edges with S_AXIS_TVALID=0 leave all state unchanged.
REQ-017 On acceptance of input word NUMBER_OF_INPUT_WORDS-1, the FSM SHALL enter WRITE_OUTPUTS on that same edge.
REQ-018 Summation SHALL be unsigned 32-bit, wrapping modulo 2^32 with no saturation or overflow flag.
REQ-019 WRITE_OUTPUTS:
- S_AXIS_TREADY=0, M_AXIS_TVALID=1, M_AXIS_TDATA=sum register.
- Output counter increments on each edge with M_AXIS_TREADY=1.
REQ-020 M_AXIS_TLAST SHALL be 1 only in WRITE_OUTPUTS while the output counter equals NUMBER_OF_OUTPUT_WORDS-1, and 0 otherwise.
REQ-021 Handshake of the final output word SHALL return the FSM to IDLE and clear both counters.
REQ-022 While M_AXIS_TREADY=0, M_AXIS_TDATA, M_AXIS_TLAST and M_AXIS_TVALID SHALL hold stable.
REQ-023 Latency: M_AXIS_TVALID SHALL rise on the clock edge that accepts the last input word (one cycle after that word is presented).
REQ-024 Inputs presented in WRITE_OUTPUTS or IDLE SHALL be neither accepted nor summed; the first word is accepted only in READ_INPUTS.
REQ-025 Back-to-back frames SHALL be supported, with one IDLE cycle between the last output and the next input acceptance.
REQ-026 All outputs SHALL be driven from registered state only, with no combinational path from any input to any output.

Reset
REQ-027 While ARESETN=0, and immediately on its assertion:
- state=IDLE, sum=0, both counters=0.
- S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no partial output; the first frame after deassertion SHALL be computed from a zero sum.
REQ-029 No input handshakes SHALL be honoured while ARESETN=0.

Structure
REQ-030 The shared package SHALL hold the state enum (IDLE, READ_INPUTS, WRITE_OUTPUTS), the data width constant (32) and the parameter default values.
REQ-031 No sub-module SHALL be used; FSM, counters and accumulator SHALL reside in myip_v1_0.

Verification
REQ-032 Reset check: hold ARESETN=0 for 2 cycles -> S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0.
REQ-033 Basic frame, M_AXIS_TREADY=1: send 0x00081000 then 0x00046000 on consecutive cycles -> one output word 0x000C7000 with M_AXIS_TLAST=1, then FSM returns to IDLE.
REQ-034 Wrap-around: send 0xFFFFFFFF then 0x00000002 -> output 0x00000001.
REQ-035 Flow control:
- S_AXIS_TVALID gapped 3 cycles between the two words -> gap ignored, and 0x00C80264 + 0x00000014 yields 0x00C80278.
- M_AXIS_TREADY=0 for 5 cycles -> output held stable, then consumed once when M_AXIS_TREADY=1.
REQ-036 Reset mid-frame: after the first word 0x10, pulse ARESETN low for 1 cycle, then send 0x5 and 0x6 -> output 0x0000000B.
REQ-037 Back-to-back frames: (1,2) then (3,4) -> outputs 0x3 then 0x7, each with M_AXIS_TLAST=1.

Source files
------------

// File: rtl/myip_v1_0_pkg.sv
// Shared definitions for the myip_v1_0 stream accumulator: data width,
// parameter defaults and FSM state encoding.
package myip_v1_0_pkg;

  localparam int unsigned DATA_WIDTH                     = 32;
  localparam int unsigned DEFAULT_NUMBER_OF_INPUT_WORDS  = 2;
  localparam int unsigned DEFAULT_NUMBER_OF_OUTPUT_WORDS = 1;
  // Wide enough to count up to 256 words per frame
  localparam int unsigned CNT_WIDTH                      = 9;

  typedef enum logic [1:0] {
    IDLE,
    READ_INPUTS,
    WRITE_OUTPUTS
  } state_t;

endpackage

// File: rtl/myip_v1_0.sv
// AXI-Stream accumulator: sums NUMBER_OF_INPUT_WORDS input words per frame and
// emits the sum NUMBER_OF_OUTPUT_WORDS times; all outputs decode registered state.
module myip_v1_0
  import myip_v1_0_pkg::*;
#(
  parameter int unsigned NUMBER_OF_INPUT_WORDS  = DEFAULT_NUMBER_OF_INPUT_WORDS,
  parameter int unsigned NUMBER_OF_OUTPUT_WORDS = DEFAULT_NUMBER_OF_OUTPUT_WORDS
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  output logic                  S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  input  logic                  S_AXIS_TVALID,
  output logic                  M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY
);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]  in_cnt;
  logic [CNT_WIDTH-1:0]  out_cnt;
  logic                  last_in;
  logic                  last_out;

  // Frame length comes from the parameter, so the slave TLAST is not used
  logic unused_tlast;
  assign unused_tlast = S_AXIS_TLAST;

  assign last_in  = (in_cnt  == CNT_WIDTH'(NUMBER_OF_INPUT_WORDS  - 1));
  assign last_out = (out_cnt == CNT_WIDTH'(NUMBER_OF_OUTPUT_WORDS - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:          if (S_AXIS_TVALID)             state_nxt = READ_INPUTS;
      READ_INPUTS:   if (S_AXIS_TVALID && last_in)  state_nxt = WRITE_OUTPUTS;
      WRITE_OUTPUTS: if (M_AXIS_TREADY && last_out) state_nxt = IDLE;
      default:                                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sum     <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          sum     <= '0;
          in_cnt  <= '0;
          out_cnt <= '0;
        end
        READ_INPUTS: begin
          if (S_AXIS_TVALID) begin
            sum    <= sum + S_AXIS_TDATA;
            in_cnt <= in_cnt + 1'b1;
          end
        end
        WRITE_OUTPUTS: begin
          if (M_AXIS_TREADY) begin
            if (last_out) begin
              in_cnt  <= '0;
              out_cnt <= '0;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: begin
          sum     <= '0;
          in_cnt  <= '0;
          out_cnt <= '0;
        end
      endcase
    end
  end

  assign S_AXIS_TREADY = (state == READ_INPUTS);
  assign M_AXIS_TVALID = (state == WRITE_OUTPUTS);
  assign M_AXIS_TDATA  = sum;
  assign M_AXIS_TLAST  = (state == WRITE_OUTPUTS) && last_out;

endmodule

// File: tb/tb_myip_v1_0.sv
// Directed bench for myip_v1_0 with default parameters (2 inputs, 1 output).
module tb_myip_v1_0;

  logic        ACLK;
  logic        ARESETN;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  myip_v1_0 #(
    .NUMBER_OF_INPUT_WORDS (2),
    .NUMBER_OF_OUTPUT_WORDS(1)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .S_AXIS_TREADY(S_AXIS_TREADY),
    .S_AXIS_TDATA (S_AXIS_TDATA),
    .S_AXIS_TLAST (S_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID),
    .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TDATA (M_AXIS_TDATA),
    .M_AXIS_TLAST (M_AXIS_TLAST),
    .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word and wait (bounded) for the edge that accepts it.
  // Returns with TVALID low, #1 after the accepting edge.
  task automatic send(input logic [31:0] data, output int unsigned cycles);
    logic accepted;
    accepted      = 1'b0;
    cycles        = 0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = data;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (S_AXIS_TREADY) accepted = 1'b1;
      @(posedge ACLK);
      #1;
      cycles++;
    end
    S_AXIS_TVALID = 1'b0;
    chk("send_accept_timeout", {31'd0, accepted}, 32'd1);
  endtask

  initial begin
    int unsigned cyc;
    logic [31:0] held;

    ARESETN       = 1'b0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    M_AXIS_TREADY = 1'b1;

    // Reset state
    repeat (2) @(posedge ACLK);
    #1;
    chk("rst_s_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
    chk("rst_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("rst_m_tlast",  {31'd0, M_AXIS_TLAST},  32'd0);
    chk("rst_m_tdata",  M_AXIS_TDATA,           32'd0);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;

    // Basic frame; TVALID rises on the edge accepting the last word
    send(32'h0008_1000, cyc);
    chk("basic_first_word_cycles", cyc, 32'd2);
    send(32'h0004_6000, cyc);
    chk("basic_second_word_cycles", cyc, 32'd1);
    chk("basic_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd1);
    chk("basic_m_tdata",  M_AXIS_TDATA,           32'h000C_7000);
    chk("basic_m_tlast",  {31'd0, M_AXIS_TLAST},  32'd1);
    chk("basic_s_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
    @(posedge ACLK);
    #1;
    chk("basic_idle_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("basic_idle_m_tlast",  {31'd0, M_AXIS_TLAST},  32'd0);
    chk("basic_idle_s_tready", {31'd0, S_AXIS_TREADY}, 32'd0);

    // Wrap-around modulo 2^32
    send(32'hFFFF_FFFF, cyc);
    send(32'h0000_0002, cyc);
    chk("wrap_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd1);
    chk("wrap_m_tdata",  M_AXIS_TDATA,           32'h0000_0001);
    @(posedge ACLK);
    #1;
    chk("wrap_done", {31'd0, M_AXIS_TVALID}, 32'd0);

    // Gapped input plus output back-pressure
    M_AXIS_TREADY = 1'b0;
    send(32'h00C8_0264, cyc);
    repeat (3) begin
      @(posedge ACLK);
      #1;
      chk("gap_no_output", {31'd0, M_AXIS_TVALID}, 32'd0);
    end
    send(32'h0000_0014, cyc);
    chk("gap_m_tdata", M_AXIS_TDATA, 32'h00C8_0278);
    held          = M_AXIS_TDATA;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = 32'h0000_0999;
    repeat (5) begin
      @(posedge ACLK);
      #1;
      chk("hold_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd1);
      chk("hold_m_tdata",  M_AXIS_TDATA,           held);
      chk("hold_m_tlast",  {31'd0, M_AXIS_TLAST},  32'd1);
      chk("hold_s_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
    end
    S_AXIS_TVALID = 1'b0;
    M_AXIS_TREADY = 1'b1;
    @(posedge ACLK);
    #1;
    chk("hold_consumed_once", {31'd0, M_AXIS_TVALID}, 32'd0);
    @(posedge ACLK);
    #1;
    chk("hold_stays_idle", {31'd0, M_AXIS_TVALID}, 32'd0);

    // Reset mid-frame: partial sum discarded
    send(32'h0000_0010, cyc);
    ARESETN       = 1'b0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = 32'h0000_0077;
    #1;
    chk("midrst_async_m_tdata",  M_AXIS_TDATA,           32'd0);
    chk("midrst_async_s_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
    @(posedge ACLK);
    #1;
    chk("midrst_s_tready", {31'd0, S_AXIS_TREADY}, 32'd0);
    chk("midrst_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    S_AXIS_TVALID = 1'b0;
    ARESETN       = 1'b1;
    @(posedge ACLK);
    #1;
    send(32'h0000_0005, cyc);
    send(32'h0000_0006, cyc);
    chk("midrst_m_tvalid_out", {31'd0, M_AXIS_TVALID}, 32'd1);
    chk("midrst_m_tdata",      M_AXIS_TDATA,           32'h0000_000B);
    @(posedge ACLK);
    #1;

    // Back-to-back frames, one IDLE cycle between them
    send(32'h0000_0001, cyc);
    send(32'h0000_0002, cyc);
    chk("b2b0_m_tdata", M_AXIS_TDATA,          32'h0000_0003);
    chk("b2b0_m_tlast", {31'd0, M_AXIS_TLAST}, 32'd1);
    @(posedge ACLK);
    #1;
    send(32'h0000_0003, cyc);
    chk("b2b1_first_word_cycles", cyc, 32'd2);
    send(32'h0000_0004, cyc);
    chk("b2b1_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd1);
    chk("b2b1_m_tdata",  M_AXIS_TDATA,           32'h0000_0007);
    chk("b2b1_m_tlast",  {31'd0, M_AXIS_TLAST},  32'd1);
    @(posedge ACLK);
    #1;
    chk("b2b1_done", {31'd0, M_AXIS_TVALID}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
